cmos_capture_addr: RTL and testbench

Downstream consumer of the picture-size stage. Accepts the raw 8-bit camera pixel bus, skips the sensor's settle frames, and packs byte pairs into RGB565 words. Emits SDRAM write strobes with a linear address that wraps at the configured frame size. Checks every captured line and frame against the configured geometry and reports frame completion and size errors to the frame-buffer controller.

---
 rtl/cmos_capture_addr_pkg.sv | 21 ++
 rtl/sig_edge_det.sv | 23 ++
 rtl/cmos_capture_addr.sv | 148 ++++++++++++++
 tb/tb_cmos_capture_addr.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmos_capture_addr_pkg.sv
// Shared widths, defaults and state encoding for the camera capture path.
package cmos_capture_addr_pkg;

   localparam int unsigned WAIT_FRAMES_DEF = 10;
   localparam int unsigned H_W             = 13;
   localparam int unsigned V_W             = 13;
   localparam int unsigned ADDR_W          = 24;
   localparam int unsigned BYTE_W          = 8;
   localparam int unsigned WORD_W          = 16;

   typedef enum logic {
      SETTLE  = 1'b0,
      CAPTURE = 1'b1
   } cap_state_e;

   // Saturating increment for the 13-bit pixel and line counters
   function automatic logic [H_W-1:0] sat_inc(input logic [H_W-1:0] val);
      return (&val) ? val : val + H_W'(1);
   endfunction

endpackage

// File: rtl/sig_edge_det.sv
// Single-edge detector: registers the input once and flags a rising or falling edge.
module sig_edge_det
   import cmos_capture_addr_pkg::*;
#(
   parameter bit FALL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sig,
   output logic edge_c
);

   logic sig_d;

   // One-cycle delayed copy of the input
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sig_d <= 1'b0;
      else        sig_d <= sig;
   end

   assign edge_c = FALL ? (~sig & sig_d) : (sig & ~sig_d);

endmodule

// File: rtl/cmos_capture_addr.sv
// Camera byte capture: settle-frame skip, RGB565 packing, wrapping SDRAM address and geometry check.
module cmos_capture_addr
   import cmos_capture_addr_pkg::*;
#(
   parameter int unsigned WAIT_FRAMES = WAIT_FRAMES_DEF,
   parameter int unsigned FCNT_W      = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmos_vsync,
   input  logic              cmos_href,
   input  logic [BYTE_W-1:0] cmos_data,
   input  logic [H_W-1:0]    cmos_h_pixel,
   input  logic [V_W-1:0]    cmos_v_pixel,
   input  logic [ADDR_W-1:0] sdram_max_addr,
   output logic              wr_en,
   output logic [WORD_W-1:0] wr_data,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              frame_done,
   output logic [FCNT_W-1:0] frame_cnt,
   output logic              size_err
);

   localparam int unsigned SC_W = (WAIT_FRAMES < 1) ? 1 : $clog2(WAIT_FRAMES + 1);

   cap_state_e        state;
   logic [SC_W-1:0]   settle_cnt;
   logic [H_W-1:0]    h_lat;
   logic [V_W-1:0]    v_lat;
   logic [ADDR_W-1:0] max_lat;
   logic [ADDR_W-1:0] addr;
   logic [H_W-1:0]    pix_cnt;
   logic [V_W-1:0]    line_cnt;
   logic              tog;
   logic [BYTE_W-1:0] hi_byte;
   logic              clr_pend;

   logic              vs_rise_c;
   logic              href_fall_c;
   logic              start_c;
   logic              active_c;
   logic              tog_c;
   logic [ADDR_W-1:0] addr_c;
   logic [ADDR_W-1:0] max_c;
   logic [H_W-1:0]    pix_c;
   logic [ADDR_W-1:0] addr_nxt_c;
   logic              line_err_c;
   logic              frame_err_c;

   sig_edge_det #(.FALL(1'b0)) u_vs_edge (
      .clk    (clk),
      .rst_n  (rst_n),
      .sig    (cmos_vsync),
      .edge_c (vs_rise_c)
   );

   sig_edge_det #(.FALL(1'b1)) u_href_edge (
      .clk    (clk),
      .rst_n  (rst_n),
      .sig    (cmos_href),
      .edge_c (href_fall_c)
   );

   // Frame-start view of the working registers: a vs_rise makes this cycle's byte the first of a new frame
   always_comb begin
      start_c     = vs_rise_c & ((state == CAPTURE) | (settle_cnt == SC_W'(WAIT_FRAMES)));
      active_c    = (state == CAPTURE) | start_c;
      tog_c       = start_c ? 1'b0 : tog;
      addr_c      = start_c ? '0 : addr;
      max_c       = start_c ? sdram_max_addr : max_lat;
      pix_c       = start_c ? '0 : pix_cnt;
      addr_nxt_c  = addr_c + ADDR_W'(1);
      if ((max_c != '0) && (addr_c == max_c - ADDR_W'(1))) addr_nxt_c = '0;
      line_err_c  = (state == CAPTURE) & ~vs_rise_c & href_fall_c & ((pix_cnt != h_lat) | tog);
      frame_err_c = (state == CAPTURE) & vs_rise_c & (line_cnt != v_lat);
   end

   // Capture FSM, packing, address generation and geometry tracking
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= SETTLE;
         settle_cnt <= '0;
         h_lat      <= '0;
         v_lat      <= '0;
         max_lat    <= '0;
         addr       <= '0;
         pix_cnt    <= '0;
         line_cnt   <= '0;
         tog        <= 1'b0;
         hi_byte    <= '0;
         clr_pend   <= 1'b0;
         wr_en      <= 1'b0;
         wr_data    <= '0;
         wr_addr    <= '0;
         frame_done <= 1'b0;
         frame_cnt  <= '0;
         size_err   <= 1'b0;
      end else begin
         wr_en      <= 1'b0;
         frame_done <= 1'b0;
         clr_pend   <= 1'b0;

         if ((state == SETTLE) && vs_rise_c && !start_c) settle_cnt <= settle_cnt + SC_W'(1);

         if (start_c) begin
            state    <= CAPTURE;
            h_lat    <= cmos_h_pixel;
            v_lat    <= cmos_v_pixel;
            max_lat  <= sdram_max_addr;
            addr     <= '0;
            pix_cnt  <= '0;
            line_cnt <= '0;
         end

         // Closing edge reports the finished frame; its error flag is dropped one cycle later
         if ((state == CAPTURE) && vs_rise_c) begin
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + FCNT_W'(1);
            size_err   <= size_err | frame_err_c;
            clr_pend   <= 1'b1;
         end else begin
            size_err   <= (clr_pend ? 1'b0 : size_err) | line_err_c;
         end

         if ((state == CAPTURE) && !vs_rise_c && href_fall_c) begin
            line_cnt <= sat_inc(line_cnt);
            pix_cnt  <= '0;
         end

         if (active_c && cmos_href) begin
            if (!tog_c) begin
               hi_byte <= cmos_data;
               tog     <= 1'b1;
            end else begin
               wr_en   <= 1'b1;
               wr_data <= {hi_byte, cmos_data};
               wr_addr <= addr_c;
               addr    <= addr_nxt_c;
               pix_cnt <= sat_inc(pix_c);
               tog     <= 1'b0;
            end
         end else begin
            tog <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cmos_capture_addr.sv
// Bench for cmos_capture_addr: frame table, collision and reset sequences, random frames against a reference model.
module tb_cmos_capture_addr;
   import cmos_capture_addr_pkg::*;

   localparam int unsigned WF     = 2;
   localparam int unsigned FCNT_W = 8;

   logic              clk;
   logic              rst_n;
   logic              cmos_vsync;
   logic              cmos_href;
   logic [7:0]        cmos_data;
   logic [12:0]       cmos_h_pixel;
   logic [12:0]       cmos_v_pixel;
   logic [23:0]       sdram_max_addr;
   logic              wr_en;
   logic [15:0]       wr_data;
   logic [23:0]       wr_addr;
   logic              frame_done;
   logic [FCNT_W-1:0] frame_cnt;
   logic              size_err;

   cmos_capture_addr #(.WAIT_FRAMES(WF), .FCNT_W(FCNT_W)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .cmos_vsync     (cmos_vsync),
      .cmos_href      (cmos_href),
      .cmos_data      (cmos_data),
      .cmos_h_pixel   (cmos_h_pixel),
      .cmos_v_pixel   (cmos_v_pixel),
      .sdram_max_addr (sdram_max_addr),
      .wr_en          (wr_en),
      .wr_data        (wr_data),
      .wr_addr        (wr_addr),
      .frame_done     (frame_done),
      .frame_cnt      (frame_cnt),
      .size_err       (size_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: frame-level bookkeeping, address = word index modulo frame size
   int      m_settle, m_words, m_hi, m_pix, m_lines, m_h, m_v, m_fcnt;
   bit      m_cap, m_pvs, m_phref, m_have_hi, m_ferr;
   longint  m_wrap;
   bit      e_wr, e_done, e_err;
   int      e_data, e_addr, e_fcnt;

   task automatic model_reset();
      m_settle = 0; m_words = 0; m_hi = 0; m_pix = 0; m_lines = 0; m_h = 0; m_v = 0;
      m_fcnt = 0; m_cap = 0; m_pvs = 0; m_phref = 0; m_have_hi = 0; m_ferr = 0; m_wrap = 1;
      e_wr = 0; e_done = 0; e_err = 0; e_data = 0; e_addr = 0; e_fcnt = 0;
   endtask

   task automatic model_step(input bit vs, input bit href, input int data,
                             input int h, input int v, input int maxa);
      bit rise, fall, started, done_err;
      rise = vs && !m_pvs;
      fall = !href && m_phref;
      m_pvs = vs; m_phref = href;
      e_wr = 0; e_done = 0; started = 0; done_err = 0;
      if (rise) begin
         if (m_cap) begin
            e_done = 1;
            m_fcnt = (m_fcnt + 1) % 256;
            if (m_lines != m_v) m_ferr = 1;
            done_err = m_ferr;
            started = 1;
         end else if (m_settle == WF) begin
            m_cap = 1;
            started = 1;
         end else begin
            m_settle++;
         end
      end
      if (started) begin
         m_h = h; m_v = v;
         m_wrap = (maxa == 0) ? (64'd1 << 24) : longint'(maxa);
         m_words = 0; m_pix = 0; m_lines = 0; m_have_hi = 0; m_ferr = 0;
      end
      if (m_cap && !rise && fall) begin
         if (m_pix != m_h || m_have_hi) m_ferr = 1;
         m_lines = (m_lines + 1 > 8191) ? 8191 : m_lines + 1;
         m_pix = 0;
      end
      if (m_cap && href) begin
         if (!m_have_hi) begin
            m_hi = data; m_have_hi = 1;
         end else begin
            e_wr = 1;
            e_data = m_hi * 256 + data;
            e_addr = int'(longint'(m_words) % m_wrap);
            m_words++;
            m_pix = (m_pix + 1 > 8191) ? 8191 : m_pix + 1;
            m_have_hi = 0;
         end
      end else begin
         m_have_hi = 0;
      end
      e_fcnt = m_fcnt;
      e_err  = e_done ? done_err : m_ferr;
   endtask

   // Collected DUT activity for the frame-level checks
   logic [23:0] wq_addr[$];
   logic [15:0] wq_data[$];
   int          n_done;
   logic        done_err;
   logic [7:0]  done_cnt;

   function automatic logic [31:0] qa(input int i);
      if (i < wq_addr.size()) return 32'(wq_addr[i]);
      return 32'hFFFF_FFFF;
   endfunction

   function automatic logic [31:0] qd(input int i);
      if (i < wq_data.size()) return 32'(wq_data[i]);
      return 32'hFFFF_FFFF;
   endfunction

   task automatic clear_collect();
      wq_addr.delete();
      wq_data.delete();
      n_done = 0;
   endtask

   // Cycle monitor: advance the model on each edge, compare just after it
   initial begin
      forever begin
         @(posedge clk);
         if (rst_n) model_step(cmos_vsync, cmos_href, int'(cmos_data),
                               int'(cmos_h_pixel), int'(cmos_v_pixel), int'(sdram_max_addr));
         #1;
         if (rst_n) begin
            chk("wr_en", 32'(wr_en), 32'(e_wr));
            if (e_wr) begin
               chk("wr_data", 32'(wr_data), 32'(e_data));
               chk("wr_addr", 32'(wr_addr), 32'(e_addr));
            end
            chk("frame_done", 32'(frame_done), 32'(e_done));
            chk("frame_cnt", 32'(frame_cnt), 32'(e_fcnt));
            chk("size_err", 32'(size_err), 32'(e_err));
            if (wr_en) begin
               wq_addr.push_back(wr_addr);
               wq_data.push_back(wr_data);
            end
            if (frame_done) begin
               n_done++;
               done_err = size_err;
               done_cnt = frame_cnt;
            end
         end
      end
   end

   task automatic cyc(input bit vs, input bit href, input logic [7:0] d);
      @(negedge clk);
      cmos_vsync = vs;
      cmos_href  = href;
      cmos_data  = d;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00);
   endtask

   task automatic vs_pulse();
      cyc(1'b1, 1'b0, 8'h00);
      cyc(1'b1, 1'b0, 8'h00);
      idle(2);
   endtask

   // Line of bytes 0x11, 0x22, ... followed by two idle cycles
   task automatic send_line(input int nbytes);
      for (int k = 0; k < nbytes; k++) cyc(1'b0, 1'b1, 8'((k + 1) * 17));
      idle(2);
   endtask

   // Four-pixel line whose first byte coincides with a vsync rising edge
   task automatic coll_line();
      for (int k = 0; k < 8; k++) cyc(k < 2, 1'b1, 8'(8'hA0 + k));
      idle(2);
   endtask

   task automatic set_cfg(input int h, input int v, input int maxa);
      cmos_h_pixel   = 13'(h);
      cmos_v_pixel   = 13'(v);
      sdram_max_addr = 24'(maxa);
   endtask

   typedef struct {
      int h, v, maxa, len0, len1;
      int n_wr, a6, alast, d0, d3;
      bit err;
   } vec_t;

   vec_t vt[7];

   initial begin
      vt[0] = '{4, 2, 100, 8, 8, 8, 6, 7, 'h1122, 'h7788, 1'b0};  // clean
      vt[1] = '{4, 2,   6, 8, 8, 8, 0, 1, 'h1122, 'h7788, 1'b0};  // wrap at 6
      vt[2] = '{4, 2, 100, 6, 8, 7, 6, 6, 'h1122, 'h1122, 1'b1};  // short line
      vt[3] = '{4, 2, 100, 8, 8, 8, 6, 7, 'h1122, 'h7788, 1'b0};  // clean after error
      vt[4] = '{4, 2, 100, 7, 8, 7, 6, 6, 'h1122, 'h1122, 1'b1};  // odd byte count
      vt[5] = '{4, 2,   0, 8, 8, 8, 6, 7, 'h1122, 'h7788, 1'b0};  // max 0 = full range
      vt[6] = '{4, 3, 100, 8, 8, 8, 6, 7, 'h1122, 'h7788, 1'b1};  // too few lines

      cmos_vsync = 0; cmos_href = 0; cmos_data = 0;
      set_cfg(4, 2, 100);
      rst_n = 0;
      model_reset();
      clear_collect();
      repeat (3) @(negedge clk);
      #1;
      chk("rst_wr_en", 32'(wr_en), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      chk("rst_size_err", 32'(size_err), 32'd0);
      @(negedge clk);
      rst_n = 1;

      // Two settle frames are discarded
      vs_pulse(); send_line(8);
      vs_pulse(); send_line(8);
      idle(2);
      chk("settle_no_done", 32'(n_done), 32'd0);
      chk("settle_no_wr", 32'(wq_addr.size()), 32'd0);

      // Table of frames, each closed by the next frame's vsync
      set_cfg(vt[0].h, vt[0].v, vt[0].maxa);
      vs_pulse();
      for (int i = 0; i < 7; i++) begin
         clear_collect();
         send_line(vt[i].len0);
         send_line(vt[i].len1);
         idle(2);
         if (i < 6) set_cfg(vt[i+1].h, vt[i+1].v, vt[i+1].maxa);
         else       set_cfg(4, 2, 100);
         vs_pulse();
         chk($sformatf("vec%0d_done", i), 32'(n_done), 32'd1);
         chk($sformatf("vec%0d_err", i), 32'(done_err), 32'(vt[i].err));
         chk($sformatf("vec%0d_nwr", i), 32'(wq_addr.size()), 32'(vt[i].n_wr));
         chk($sformatf("vec%0d_a6", i), qa(6), 32'(vt[i].a6));
         chk($sformatf("vec%0d_alast", i), qa(vt[i].n_wr - 1), 32'(vt[i].alast));
         chk($sformatf("vec%0d_d0", i), qd(0), 32'(vt[i].d0));
         chk($sformatf("vec%0d_d3", i), qd(3), 32'(vt[i].d3));
      end

      // Collision after a complete 2-line frame: prior frame clean, new pixel at address 0
      clear_collect();
      send_line(8); send_line(8);
      coll_line();
      idle(2);
      chk("coll1_done", 32'(n_done), 32'd1);
      chk("coll1_err", 32'(done_err), 32'd0);
      chk("coll1_addr", qa(8), 32'd0);
      chk("coll1_data", qd(8), 32'h0000_A0A1);
      chk("coll1_addr2", qa(9), 32'd1);

      // Collision closing a 1-line frame: line count mismatch reported
      clear_collect();
      coll_line();
      idle(2);
      chk("coll2_done", 32'(n_done), 32'd1);
      chk("coll2_err", 32'(done_err), 32'd1);
      chk("coll2_addr", qa(0), 32'd0);
      chk("coll2_data", qd(0), 32'h0000_A0A1);

      // Random frames against the model
      for (int r = 0; r < 40; r++) begin
         int h, v, nl, nb;
         h  = $urandom_range(1, 5);
         v  = $urandom_range(1, 3);
         set_cfg(h, v, $urandom_range(0, 12));
         if ($urandom_range(0, 3) == 0) begin
            for (int k = 0; k < 2 * h; k++) cyc(k < 2, 1'b1, 8'($urandom));
            idle(2);
         end else begin
            vs_pulse();
         end
         nl = v + $urandom_range(0, 2) - 1;
         for (int l = 0; l < nl; l++) begin
            nb = 2 * h;
            if ($urandom_range(0, 3) == 0) nb = nb + $urandom_range(0, 3) - 1;
            for (int k = 0; k < nb; k++) cyc(1'b0, 1'b1, 8'($urandom));
            idle($urandom_range(1, 3));
         end
      end
      set_cfg(4, 2, 100);
      vs_pulse();

      // Reset in the middle of a line
      cyc(1'b0, 1'b1, 8'h11); cyc(1'b0, 1'b1, 8'h22); cyc(1'b0, 1'b1, 8'h33);
      @(negedge clk);
      rst_n = 0;
      cmos_href = 0; cmos_vsync = 0; cmos_data = 0;
      model_reset();
      #1;
      chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
      chk("mid_rst_wr_data", 32'(wr_data), 32'd0);
      chk("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
      chk("mid_rst_frame_done", 32'(frame_done), 32'd0);
      chk("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
      chk("mid_rst_size_err", 32'(size_err), 32'd0);
      idle(2);
      @(negedge clk);
      rst_n = 1;
      clear_collect();
      vs_pulse(); send_line(8); send_line(8);
      vs_pulse(); send_line(8); send_line(8);
      idle(2);
      chk("post_rst_settle_done", 32'(n_done), 32'd0);
      chk("post_rst_settle_wr", 32'(wq_addr.size()), 32'd0);
      vs_pulse(); send_line(8); send_line(8);
      vs_pulse();
      chk("post_rst_done", 32'(n_done), 32'd1);
      chk("post_rst_cnt", 32'(done_cnt), 32'd1);
      chk("post_rst_err", 32'(done_err), 32'd0);
      chk("post_rst_nwr", 32'(wq_addr.size()), 32'd8);
      chk("post_rst_a0", qa(0), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
